fetch_queue: RTL
================

// Module: fetch_queue
// PURPOSE
//  Instruction buffer between the fetch stage and the decode stage. Captures
//  fetched {pc, instr} pairs with a valid/ready handshake and presents them
//  to decode in program order. Decouples fetch from decode stalls.
//  Drops all buffered entries on a redirect flush.
// PARAMETERS
//  DEPTH  4  entry count; power of two, >= 2
// PORTS
//  clk_i        in   1        clock, all state updates on posedge
//  rst_n_i      in   1        synchronous active-low reset
//  flush_i      in   1        discard all entries (branch/jump redirect)
//  in_valid_i   in   1        fetch presents a valid pc/instr
//  in_ready_o   out  1        queue accepts a push this cycle
//  in_pc_i      in   word_t   pc of the fetched instruction
//  in_instr_i   in   word_t   fetched instruction word
//  out_valid_o  out  1        head entry valid for decode
//  out_ready_i  in   1        decode consumes head this cycle
//  out_pc_o     out  word_t   pc of head entry
//  out_instr_o  out  word_t   instruction of head entry
//  count_o      out  $clog2(DEPTH)+1  number of occupied entries
// BEHAVIOUR
//  - One clock (clk_i). Reset is synchronous and active-low (rst_n_i), sampled on posedge.
//  - Storage: DEPTH-entry circular array; rd_ptr, wr_ptr are $clog2(DEPTH)
//    bits and wrap naturally DEPTH-1 -> 0; count is $clog2(DEPTH)+1 bits.
//  - push = in_valid_i & in_ready_o; pop = out_valid_o & out_ready_i.
//  - in_ready_o  = (count != DEPTH); depends only on registered state, no
//    combinational path from out_ready_i. Full + pop in same cycle: no push.
//  - out_valid_o = (count != 0). out_pc_o/out_instr_o = entry[rd_ptr] when
//    valid, 0 when empty.
//  - No bypass: a pushed entry is visible at the output earliest the next
//    cycle (latency 1). Empty + push + out_ready_i: no pop, count -> 1.
//  - push only: write entry[wr_ptr], wr_ptr+1, count+1.
//  - pop only: rd_ptr+1, count-1.
//  - push & pop: write, both ptrs +1, count unchanged.
//  - flush_i = 1 (rst_n_i high): rd_ptr, wr_ptr, count -> 0; any push or pop
//    that cycle is ignored; out_valid_o = 0 the following cycle. Flush
//    takes priority over all handshakes.
//  - rst_n_i = 0: rd_ptr, wr_ptr, count -> 0 at posedge; push/pop ignored.
//    After reset: out_valid_o=0, out_pc_o=0, out_instr_o=0, count_o=0,
//    in_ready_o=1. Reset mid-operation discards all entries identically.
//  - Entry storage contents need no reset; outputs are gated by count.
//  - Reset takes priority over flush.
// TESTING
//  1. Reset, push pc=0x0,0x4,0x8,0xC, out_ready_i=0 -> count_o=4,
//     in_ready_o=0; 5th push (pc=0x10) not accepted, count stays 4.
//  2. Drain with out_ready_i=1 -> out_pc_o 0x0,0x4,0x8,0xC on 4 consecutive
//     cycles with matching instr; then out_valid_o=0, outputs 0.
//  3. count=2, push & pop every cycle for 10 cycles -> count_o stays 2,
//     order preserved across pointer wrap.
//  4. Empty queue, push instr=0x00000013 with out_ready_i=1 -> no pop that
//     cycle; next cycle out_valid_o=1, out_instr_o=0x00000013.
//  5. count=3, flush_i=1 with simultaneous push & pop -> next cycle count_o=0,
//     out_valid_o=0, in_ready_o=1; pushed entry absent.
//  6. count=3, rst_n_i=0 for 1 cycle with in_valid_i=1 -> count_o=0,
//     out_valid_o=0, out_pc_o=0; subsequent push behaves as from empty.

Source files
------------

// File: rtl/fetch_queue_if.sv
// Fetch-to-decode handshake bundle: push side from fetch, pop side to decode.
interface fetch_queue_if #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned XLEN  = 32
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic            in_valid_i;
    logic            in_ready_o;
    logic [XLEN-1:0] in_pc_i;
    logic [XLEN-1:0] in_instr_i;
    logic            out_valid_o;
    logic            out_ready_i;
    logic [XLEN-1:0] out_pc_o;
    logic [XLEN-1:0] out_instr_o;
    logic [CW-1:0]   count_o;

    modport master (
        output in_valid_i, in_pc_i, in_instr_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_pc_o, out_instr_o, count_o
    );

    modport slave (
        input  in_valid_i, in_pc_i, in_instr_i, out_ready_i,
        output in_ready_o, out_valid_o, out_pc_o, out_instr_o, count_o
    );
endinterface

// File: rtl/fetch_queue.sv
// In-order instruction buffer between fetch and decode; flush drops all entries.
module fetch_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned XLEN  = 32
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          flush_i,
    fetch_queue_if.slave  bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [CW-1:0]   count;
    logic [XLEN-1:0] pc_mem    [DEPTH];
    logic [XLEN-1:0] instr_mem [DEPTH];

    logic full_c;
    logic empty_c;
    logic push_c;
    logic pop_c;

    // Handshake qualifiers depend only on registered occupancy.
    assign full_c  = (count == CW'(DEPTH));
    assign empty_c = (count == '0);
    assign push_c  = bus.in_valid_i & ~full_c;
    assign pop_c   = bus.out_ready_i & ~empty_c;

    assign bus.in_ready_o  = ~full_c;
    assign bus.out_valid_o = ~empty_c;
    assign bus.out_pc_o    = empty_c ? '0 : pc_mem[rd_ptr];
    assign bus.out_instr_o = empty_c ? '0 : instr_mem[rd_ptr];
    assign bus.count_o     = count;

    // Pointer and occupancy state; reset beats flush, flush beats handshakes.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_c) wr_ptr <= wr_ptr + PW'(1);
            if (pop_c)  rd_ptr <= rd_ptr + PW'(1);
            if (push_c && !pop_c)      count <= count + CW'(1);
            else if (pop_c && !push_c) count <= count - CW'(1);
        end
    end

    // Entry storage is not reset; outputs are gated by occupancy.
    always_ff @(posedge clk_i) begin
        if (rst_n_i && !flush_i && push_c) begin
            pc_mem[wr_ptr]    <= bus.in_pc_i;
            instr_mem[wr_ptr] <= bus.in_instr_i;
        end
    end
endmodule
